// File: rtl/reg_access_arbiter_if.sv
// Bundle of signals for the two register-file requesters and for the register-file port itself.
// The arbiter connects through the slave modport; the requesters and the register file use master.
interface reg_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              aReq;
    logic              aWe;
    logic [ADDR_W-1:0] aAddr;
    logic [DATA_W-1:0] aWdata;
    logic              aAck;
    logic [DATA_W-1:0] aRdata;

    logic              bReq;
    logic              bWe;
    logic [ADDR_W-1:0] bAddr;
    logic [DATA_W-1:0] bWdata;
    logic              bAck;
    logic [DATA_W-1:0] bRdata;

    logic [ADDR_W-1:0] regAddr;
    logic [DATA_W-1:0] regDataIn;
    logic              regWriteEn;
    logic [DATA_W-1:0] regDataOut;

    logic              busy;
    logic              owner;

    modport slave (
        input  aReq, aWe, aAddr, aWdata,
        input  bReq, bWe, bAddr, bWdata,
        input  regDataOut,
        output aAck, aRdata, bAck, bRdata,
        output regAddr, regDataIn, regWriteEn,
        output busy, owner
    );

    modport master (
        output aReq, aWe, aAddr, aWdata,
        output bReq, bWe, bAddr, bWdata,
        output regDataOut,
        input  aAck, aRdata, bAck, bRdata,
        input  regAddr, regDataIn, regWriteEn,
        input  busy, owner
    );
endinterface

// File: rtl/reg_access_arbiter.sv
// Two-requester arbiter and sequencer for the register-file port.
// Default arbitration is round-robin; define REG_ARB_FIXED_PRIO_EN to make requester A always win ties.
module reg_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_access_arbiter_if.slave   io_bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCESS     = 2'd1,
        RD_CAPTURE = 2'd2,
        ACK        = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_regAddr;
    logic [DATA_W-1:0] r_regDataIn;
    logic              r_regWriteEn;
    logic              r_owner;
    logic [DATA_W-1:0] r_aRdata;
    logic [DATA_W-1:0] r_bRdata;

    logic              w_grant;
    logic              w_win_b;
    logic              w_aAck;
    logic              w_bAck;

`ifndef REG_ARB_FIXED_PRIO_EN
    logic              r_rrPtr;
`endif

    assign w_grant = (r_state == IDLE) && (io_bus.aReq || io_bus.bReq);

`ifdef REG_ARB_FIXED_PRIO_EN
    assign w_win_b = !io_bus.aReq;
`else
    // r_rrPtr names the requester that wins a tie; a lone requester always wins
    assign w_win_b = io_bus.bReq && (!io_bus.aReq || r_rrPtr);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_aAck = 1'b0;
        w_bAck = 1'b0;
        case (r_state)
            IDLE:       if (w_grant) w_next = ACCESS;
            // the write strobe still carries the latched direction during ACCESS
            ACCESS:     w_next = r_regWriteEn ? ACK : RD_CAPTURE;
            RD_CAPTURE: w_next = ACK;
            ACK: begin
                w_next = IDLE;
                w_aAck = ~r_owner;
                w_bAck = r_owner;
            end
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regAddr    <= '0;
            r_regDataIn  <= '0;
            r_regWriteEn <= 1'b0;
            r_owner      <= 1'b0;
            r_aRdata     <= '0;
            r_bRdata     <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
            r_rrPtr      <= 1'b0;
`endif
        end else begin
            if (w_grant) begin
                r_regAddr    <= w_win_b ? io_bus.bAddr  : io_bus.aAddr;
                r_regDataIn  <= w_win_b ? io_bus.bWdata : io_bus.aWdata;
                r_regWriteEn <= w_win_b ? io_bus.bWe    : io_bus.aWe;
                r_owner      <= w_win_b;
`ifndef REG_ARB_FIXED_PRIO_EN
                r_rrPtr      <= ~w_win_b;
`endif
            end
            if (r_state == ACCESS) begin
                r_regWriteEn <= 1'b0;
            end
            // register file output is valid here, one cycle after the address was presented
            if (r_state == RD_CAPTURE) begin
                if (r_owner) begin
                    r_bRdata <= io_bus.regDataOut;
                end else begin
                    r_aRdata <= io_bus.regDataOut;
                end
            end
        end
    end

    assign io_bus.regAddr    = r_regAddr;
    assign io_bus.regDataIn  = r_regDataIn;
    assign io_bus.regWriteEn = r_regWriteEn;
    assign io_bus.owner      = r_owner;
    assign io_bus.aRdata     = r_aRdata;
    assign io_bus.bRdata     = r_bRdata;
    assign io_bus.aAck       = w_aAck;
    assign io_bus.bAck       = w_bAck;
    assign io_bus.busy       = (r_state != IDLE);

endmodule
